// File: rtl/soc_addr_decoder_pkg.sv
// SoC address map shared by request-side decode logic: slave enum, windows, decode helper.
// Enum value of each slave equals its bit position in the one-hot select.
package soc_addr_decoder_pkg;

    localparam int SocNrSlaves = 10;
    localparam int AddrMapW    = 64;

    typedef enum logic [3:0] {
        SLV_DRAM    = 4'd0,
        SLV_LLC_CFG = 4'd1,
        SLV_GPIO    = 4'd2,
        SLV_ETH     = 4'd3,
        SLV_SPI     = 4'd4,
        SLV_UART    = 4'd5,
        SLV_PLIC    = 4'd6,
        SLV_CLINT   = 4'd7,
        SLV_ROM     = 4'd8,
        SLV_DEBUG   = 4'd9
    } slv_e;

    typedef struct packed {
        logic hit;
        slv_e idx;
    } dec_t;

    localparam logic [AddrMapW-1:0] SlvBase [SocNrSlaves] = '{
        64'h0000_0000_8000_0000,
        64'h0000_0000_5000_0000,
        64'h0000_0000_4000_0000,
        64'h0000_0000_3000_0000,
        64'h0000_0000_2000_0000,
        64'h0000_0000_1000_0000,
        64'h0000_0000_0C00_0000,
        64'h0000_0000_0200_0000,
        64'h0000_0000_0001_0000,
        64'h0000_0000_0000_0000
    };

    localparam logic [AddrMapW-1:0] SlvLen [SocNrSlaves] = '{
        64'h0000_0000_4000_0000,
        64'h0000_0000_0000_1000,
        64'h0000_0000_0000_1000,
        64'h0000_0000_0001_0000,
        64'h0000_0000_0080_0000,
        64'h0000_0000_0000_1000,
        64'h0000_0000_03FF_FFFF,
        64'h0000_0000_000C_0000,
        64'h0000_0000_0001_0000,
        64'h0000_0000_0000_1000
    };

    // Windows never overlap, so the first hit is the only hit; holes (Timer, LlcSpm) miss.
    function automatic dec_t decode_addr(input logic [AddrMapW-1:0] addr);
        dec_t res;
        res.hit = 1'b0;
        res.idx = SLV_DRAM;
        for (int i = 0; i < SocNrSlaves; i++) begin
            if (!res.hit && (addr >= SlvBase[i]) && (addr < SlvBase[i] + SlvLen[i])) begin
                res.hit = 1'b1;
                res.idx = slv_e'(4'(i));
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/soc_addr_decoder_cnt.sv
// Saturating up/down counter of in-flight transactions with empty/full flags.
// Latency: count updates one cycle after inc/dec. Backpressure: none; inc at full and dec at empty are dropped.
// Simultaneous inc and dec leave the count unchanged.
module soc_addr_decoder_cnt #(
    parameter int MaxOutstanding = 8,
    parameter int CntW           = $clog2(MaxOutstanding) + 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            inc_i,
    input  logic            dec_i,
    output logic [CntW-1:0] cnt_o,
    output logic            empty_o,
    output logic            full_o
);

    logic [CntW-1:0] cnt_q;
    logic [CntW-1:0] cnt_d;
    logic            do_inc;
    logic            do_dec;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CntW'(MaxOutstanding));
    assign cnt_o   = cnt_q;
    assign do_inc  = inc_i && !full_o;
    assign do_dec  = dec_i && !empty_o;

    always_comb begin
        cnt_d = cnt_q;
        if (do_inc && !do_dec) begin
            cnt_d = cnt_q + CntW'(1);
        end else if (do_dec && !do_inc) begin
            cnt_d = cnt_q - CntW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    a_rsp_underflow: assert property (@(posedge clk_i) disable iff (rst_i) !(dec_i && empty_o));

endmodule

// File: rtl/soc_addr_decoder.sv
// Request decode stage ahead of the crossbar: one-entry slot, one-hot slave select, local decode errors.
// Latency: mapped request on slv_* 1 cycle after accept; unmapped error 2 cycles after accept when idle.
// Backpressure: req_ready_o only while the slot is empty; issue stalls on target change or full outstanding.
module soc_addr_decoder
    import soc_addr_decoder_pkg::*;
#(
    parameter int AddrWidth      = 64,
    parameter int IdWidth        = 4,
    parameter int NrSlaves       = SocNrSlaves,
    parameter int MaxOutstanding = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic [AddrWidth-1:0] req_addr_i,
    input  logic                 req_we_i,
    input  logic [IdWidth-1:0]   req_id_i,
    output logic                 slv_valid_o,
    input  logic                 slv_ready_i,
    output logic [NrSlaves-1:0]  slv_sel_o,
    output logic [AddrWidth-1:0] slv_addr_o,
    output logic                 slv_we_o,
    output logic [IdWidth-1:0]   slv_id_o,
    input  logic                 rsp_done_i,
    output logic                 err_valid_o,
    input  logic                 err_ready_i,
    output logic [IdWidth-1:0]   err_id_o,
    output logic                 err_we_o,
    output logic                 busy_o
);

    localparam int CntW = $clog2(MaxOutstanding) + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN,
        ST_ERR
    } state_e;

    state_e                 state_q, state_d;
    logic [AddrWidth-1:0]   addr_q, addr_d;
    logic                   we_q, we_d;
    logic [IdWidth-1:0]     id_q, id_d;
    slv_e                   tgt_q, tgt_d;
    slv_e                   last_q, last_d;

    dec_t                   req_dec;
    logic                   can_issue;
    logic                   issue;
    logic [CntW-1:0]        cnt;
    logic                   cnt_empty;
    logic                   cnt_full;

    assign req_dec = decode_addr(AddrMapW'(req_addr_i));

    // Same-target ordering: switching slaves only once every earlier response is back.
    assign can_issue = (cnt_empty || (tgt_q == last_q)) && !cnt_full;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        we_d        = we_q;
        id_d        = id_q;
        tgt_d       = tgt_q;
        last_d      = last_q;
        slv_valid_o = 1'b0;
        issue       = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (req_valid_i) begin
                    addr_d  = req_addr_i;
                    we_d    = req_we_i;
                    id_d    = req_id_i;
                    tgt_d   = req_dec.idx;
                    state_d = req_dec.hit ? ST_ISSUE : ST_DRAIN;
                end
            end
            ST_ISSUE: begin
                slv_valid_o = can_issue;
                if (can_issue && slv_ready_i) begin
                    issue   = 1'b1;
                    last_d  = tgt_q;
                    state_d = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (cnt_empty) begin
                    state_d = ST_ERR;
                end
            end
            ST_ERR: begin
                if (err_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            we_q    <= 1'b0;
            id_q    <= '0;
            tgt_q   <= SLV_DRAM;
            last_q  <= SLV_DRAM;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            id_q    <= id_d;
            tgt_q   <= tgt_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        slv_sel_o = '0;
        if (slv_valid_o) begin
            slv_sel_o[tgt_q] = 1'b1;
        end
    end

    assign req_ready_o = !rst_i && (state_q == ST_IDLE);
    assign slv_addr_o  = addr_q;
    assign slv_we_o    = we_q;
    assign slv_id_o    = id_q;
    assign err_valid_o = (state_q == ST_ERR);
    assign err_id_o    = id_q;
    assign err_we_o    = we_q;
    assign busy_o      = !cnt_empty || (state_q != ST_IDLE);

    soc_addr_decoder_cnt #(
        .MaxOutstanding(MaxOutstanding),
        .CntW          (CntW)
    ) u_cnt (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .inc_i  (issue),
        .dec_i  (rsp_done_i),
        .cnt_o  (cnt),
        .empty_o(cnt_empty),
        .full_o (cnt_full)
    );

endmodule
